div_hilo_ctrl: RTL and testbench
================================

# div_hilo_ctrl

- Sequencing stage between the execute stage and the iterative 32-bit signed divider.
- Accepts DIV/DIVU from the pipeline and selects the operands. It launches the divider with a one-cycle start pulse, tracks its busy flag, applies the unsigned correction, and writes the quotient and remainder into the architectural LO/HI registers.
- Also owns MTHI/MTLO writes and provides the pipeline stall.

## Interface
- DIV_TIMEOUT, 40: maximum cycles spent in ACK+RUN before the operation is aborted.

- clock  in  1  system clock; all block state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  DIV/DIVU issued this cycle.
- op_signed  in  1  1 = DIV, 0 = DIVU.
- op_a  in  32  dividend (rs).
- op_b  in  32  divisor (rt).
- mthi  in  1  write wdata to HI.
- mtlo  in  1  write wdata to LO.
- wdata  in  32  MTHI/MTLO data.
- stall  out  1  pipeline must hold.
- hi  out  32  HI register (remainder).
- lo  out  32  LO register (quotient).
- timeout_err  out  1  sticky abort flag.
- div_start  out  1  divider start; registered pulse, exactly one clock period wide.
- div_dividend  out  32  divider dividend, registered.
- div_divisor  out  32  divider divisor, registered.
- div_busy  in  1  divider busy.
- div_q  in  32  divider quotient.
- div_r  in  32  divider remainder.

## Operation
- States: IDLE, LAUNCH, ACK, RUN, FIX, WB.
- Reset (reset=0, any state):
  - state=IDLE; hi=lo=0; div_start=0; div_dividend=div_divisor=0.
  - timeout_err=0; timeout counter=0.
- IDLE, op_valid=1: classified by op_b and op_signed.
  - Zero divisor (op_b=0, either signedness): hi<=op_a, lo<=32'hFFFFFFFF on the same edge; stays IDLE.
  - Unsigned large divisor (!op_signed && op_b[31]): the quotient is q=(op_a>=op_b).
    - lo<=q, hi<=op_a-(q?op_b:0) on the same edge; stays IDLE.
  - Direct path (op_signed, or both MSBs clear): div_dividend<=op_a, div_divisor<=op_b, fix flag=0 → LAUNCH.
  - Fix path (!op_signed && op_a[31] && !op_b[31]): div_dividend<={1'b0,op_a[31:1]}, div_divisor<=op_b.
    - Latch op_a[0] and op_b; fix flag=1 → LAUNCH.
- IDLE, mthi/mtlo without op_valid: hi/lo<=wdata; mthi and mtlo may both be asserted.
  - When op_valid is also asserted, op_valid has priority and mthi/mtlo are ignored.
- mthi/mtlo in any non-IDLE state: ignored.
- op_valid outside IDLE: ignored; the pipeline is stalled.
- LAUNCH: div_start=1 for this cycle only → ACK.
- ACK: stays while div_busy=0; div_busy=1 → RUN.
- RUN: stays while div_busy=1. div_busy=0 → latch q=div_q, r=div_r, then:
  - fix flag=0 → WB.
  - fix flag=1 → FIX.
- FIX (unsigned correction):
  - q2={q[30:0],1'b0}; r2={r[30:0],a0}.
  - If r2>=b: q<=q2+1, r<=r2-b. Otherwise q<=q2, r<=r2.
  - → WB.
- WB: lo<=q, hi<=r → IDLE.
- Timeout: the counter clears on entry to LAUNCH and increments each cycle in ACK/RUN.
  - Reaching DIV_TIMEOUT → timeout_err<=1 (sticky until reset), → IDLE, hi/lo unchanged.
- Signed overflow (0x80000000 / -1): the divider result is written unchanged: lo=0x80000000, hi=0.
- stall = (state!=IDLE) | (state==IDLE & op_valid & path needs divider).
- hi, lo: driven directly from the registers.

## Timing
- Fast paths: zero stall cycles; hi/lo visible the cycle after the accept edge.
- Divider path, accept at edge P0:
  - LAUNCH during P0–P1; the divider samples div_start on the falling edge inside that cycle.
  - ACK at P1, RUN at P2.
  - The divider drops busy 32 falling edges later; RUN observes div_busy=0 at P33.
- Write-back edge:
  - Direct path: hi/lo written at P34, stall low from P34.
  - Fix path: hi/lo written at P35, stall low from P35.
- div_start is never high in two consecutive cycles. A new op is accepted no earlier than the edge at which stall drops.

## Test plan
- Signed DIV 100/7 → lo=14, hi=2.
  - div_start is a single one-cycle pulse.
  - stall high from the accept cycle through the WB edge (34 edges).
- Signed DIV -7/2 (0xFFFFFFF9 / 2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0xFFFFFFFF/3 (fix path) → div_dividend=0x7FFFFFFF; lo=0x55555555, hi=0; one extra cycle versus the direct path.
- Fast paths, no stall:
  - DIVU 0x80000001/0x80000000 → lo=1, hi=1.
  - DIV 5/0 → lo=0xFFFFFFFF, hi=5.
  - mtlo with op_valid in the same cycle → mtlo ignored.
- Reset mid-RUN:
  - Pull reset low asynchronously → hi=lo=0, state IDLE, stall=0 immediately.
  - After release, a new DIV 9/3 → lo=3, hi=0.
- Divider model holding div_busy=1 indefinitely → timeout_err=1 after 40 ACK/RUN cycles; hi/lo keep their prior values; stall released.

Source files
------------

// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl: sequencer between execute and the iterative 32-bit signed divider.
// Classifies DIV/DIVU, resolves the trivial cases in one edge, launches the
// divider for the rest, applies the one-step unsigned correction and retires
// quotient/remainder into LO/HI. Also owns MTHI/MTLO and the pipeline stall.
//
// Ports:
//   clock, reset            clock, async active-low reset
//   op_valid/op_signed      DIV (signed=1) / DIVU (signed=0) issue
//   op_a, op_b              dividend (rs), divisor (rt)
//   mthi, mtlo, wdata       HI/LO move-to writes (IDLE only, op_valid wins)
//   stall                   pipeline must hold
//   hi, lo                  architectural HI (remainder) / LO (quotient)
//   timeout_err             sticky: a divide was aborted for taking too long
//   div_start               one-cycle registered launch pulse
//   div_dividend/divisor    registered divider operands
//   div_busy, div_q, div_r  divider status and results
module div_hilo_ctrl #(
    parameter int DIV_TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        timeout_err,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_busy,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r
);
    localparam int CW = $clog2(DIV_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, ACK, RUN, FIX, WB} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          fix_flag;
    logic          a0;
    logic [31:0]   b_lat;
    logic [31:0]   q, r;

    // Operand classification for an op arriving in IDLE.
    logic zero_div, big_div, fix_div, need_div, q_big;
    assign zero_div = (op_b == 32'd0);
    assign big_div  = !op_signed && op_b[31];
    assign fix_div  = !op_signed && op_a[31] && !op_b[31];
    assign need_div = !zero_div && !big_div;
    // Divisor >= 2^31 unsigned: quotient can only be 0 or 1.
    assign q_big    = (op_a >= op_b);

    // Unsigned correction: the divider saw a>>1, so shift one bit back in.
    // r < b < 2^31, hence r2 never overflows 32 bits.
    logic [31:0] q2, r2;
    assign q2 = {q[30:0], 1'b0};
    assign r2 = {r[30:0], a0};

    assign tmo_hit = (tmo_cnt == CW'(DIV_TIMEOUT - 1));
    assign stall   = (state != IDLE) || (op_valid && need_div);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (op_valid && need_div) state_nx = LAUNCH;
            LAUNCH:  state_nx = ACK;
            ACK:     if (tmo_hit) state_nx = IDLE;
                     else if (div_busy) state_nx = RUN;
            RUN:     if (tmo_hit) state_nx = IDLE;
                     else if (!div_busy) state_nx = fix_flag ? FIX : WB;
            FIX:     state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Timeout counter and sticky abort flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state_nx == LAUNCH)
                tmo_cnt <= '0;
            else if (state == ACK || state == RUN)
                tmo_cnt <= tmo_cnt + 1'b1;
            if ((state == ACK || state == RUN) && tmo_hit)
                timeout_err <= 1'b1;
        end
    end

    // Datapath: operand capture, result latch, correction, HI/LO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi           <= '0;
            lo           <= '0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            fix_flag     <= 1'b0;
            a0           <= 1'b0;
            b_lat        <= '0;
            q            <= '0;
            r            <= '0;
        end else begin
            // LAUNCH is only ever entered from IDLE, so this is a single pulse.
            div_start <= (state_nx == LAUNCH);
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        if (zero_div) begin
                            hi <= op_a;
                            lo <= 32'hFFFF_FFFF;
                        end else if (big_div) begin
                            lo <= {31'd0, q_big};
                            hi <= op_a - (q_big ? op_b : 32'd0);
                        end else begin
                            div_dividend <= fix_div ? {1'b0, op_a[31:1]} : op_a;
                            div_divisor  <= op_b;
                            fix_flag     <= fix_div;
                            a0           <= op_a[0];
                            b_lat        <= op_b;
                        end
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    if (!div_busy) begin
                        q <= div_q;
                        r <= div_r;
                    end
                end
                FIX: begin
                    if (r2 >= b_lat) begin
                        q <= q2 + 32'd1;
                        r <= r2 - b_lat;
                    end else begin
                        q <= q2;
                        r <= r2;
                    end
                end
                WB: begin
                    lo <= q;
                    hi <= r;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Bench for div_hilo_ctrl: divider behavioural model, arithmetic reference
// model with per-cycle compare, directed literal checks, random stimulus.
module tb_div_hilo_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0, op_signed = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [31:0] op_a = '0, op_b = '0, wdata = '0;
    logic        stall, timeout_err, div_start;
    logic [31:0] hi, lo, div_dividend, div_divisor;
    logic        div_busy;
    logic [31:0] div_q, div_r;
    logic        hang = 1'b0;

    int nvec = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    div_hilo_ctrl #(.DIV_TIMEOUT(40)) dut (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_signed(op_signed),
        .op_a(op_a), .op_b(op_b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .stall(stall), .hi(hi), .lo(lo), .timeout_err(timeout_err),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_busy(div_busy), .div_q(div_q), .div_r(div_r)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain arithmetic result {lo, hi} of DIV/DIVU.
    function automatic logic [63:0] ref_result(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, qq, rr;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (!s) return {a / b, a % b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        qq = sa / sb;
        rr = sa % sb;
        return {qq[31:0], rr[31:0]};
    endfunction

    function automatic logic needs_div(input logic s, input logic [31:0] b);
        return (b != 32'd0) && !(!s && b[31]);
    endfunction

    // Iterative signed divider: samples start on falling edge, busy for 32 falling edges.
    int dleft;
    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            div_busy <= 1'b0;
            dleft    <= 0;
            div_q    <= '0;
            div_r    <= '0;
        end else if (div_start) begin
            div_busy       <= 1'b1;
            dleft          <= 32;
            {div_q, div_r} <= ref_result(1'b1, div_dividend, div_divisor);
        end else if (div_busy && !hang) begin
            if (dleft == 1) div_busy <= 1'b0;
            dleft <= dleft - 1;
        end
    end

    // Reference model: an accepted divide retires after a fixed number of edges.
    logic [31:0] m_hi, m_lo, p_hi, p_lo, m_dvd, m_dvs;
    logic        m_err, m_to;
    int          pend, age;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_hi <= '0; m_lo <= '0; m_err <= 1'b0; m_to <= 1'b0;
            pend <= 0; age <= 0; p_hi <= '0; p_lo <= '0; m_dvd <= '0; m_dvs <= '0;
        end else if (pend > 0) begin
            pend <= pend - 1;
            age  <= age + 1;
            if (pend == 1) begin
                if (m_to) m_err <= 1'b1;
                else begin m_hi <= p_hi; m_lo <= p_lo; end
            end
        end else if (op_valid) begin
            if (needs_div(op_signed, op_b)) begin
                pend  <= hang ? 41 : ((!op_signed && op_a[31] && !op_b[31]) ? 35 : 34);
                m_to  <= hang;
                age   <= 0;
                {p_lo, p_hi} <= ref_result(op_signed, op_a, op_b);
                m_dvd <= (!op_signed && op_a[31]) ? {1'b0, op_a[31:1]} : op_a;
                m_dvs <= op_b;
            end else begin
                {m_lo, m_hi} <= ref_result(op_signed, op_a, op_b);
            end
        end else begin
            if (mthi) m_hi <= wdata;
            if (mtlo) m_lo <= wdata;
        end
    end

    // Per-cycle compare on the falling edge.
    always @(negedge clock) begin
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("timeout_err", timeout_err, m_err);
        chk("stall", stall, (pend > 0) || (op_valid && needs_div(op_signed, op_b)));
        chk("div_start", div_start, (pend > 0) && (age == 0));
        if (pend > 0 && age == 0) begin
            chk("div_dividend", div_dividend, m_dvd);
            chk("div_divisor", div_divisor, m_dvs);
        end
    end

    // Drive one op for one cycle; returns at accept edge + 1.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic ml, input logic [31:0] wd, output logic acc_stall);
        @(posedge clock); #1;
        op_valid = 1'b1; op_signed = s; op_a = a; op_b = b; mtlo = ml; wdata = wd;
        #1 acc_stall = stall;
        @(posedge clock); #1;
        op_valid = 1'b0; mtlo = 1'b0;
    endtask

    task automatic mt(input logic [31:0] h, input logic [31:0] l);
        @(posedge clock); #1;
        mthi = 1'b1; wdata = h;
        @(posedge clock); #1;
        mthi = 1'b0; mtlo = 1'b1; wdata = l;
        @(posedge clock); #1;
        mtlo = 1'b0;
    endtask

    task automatic wait_idle(output int k, output int pulses);
        k = 0;
        pulses = int'(div_start);
        while (stall && k < 100) begin
            @(posedge clock); #1;
            k++;
            pulses += int'(div_start);
        end
        if (k >= 100) chk("wait_idle_timeout", 32'(k), 32'd0);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int   k, pulses;
        logic acc;
        #1 reset = 1'b0;
        #20;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", stall, 32'd0);
        chk("rst_terr", timeout_err, 32'd0);
        chk("rst_start", div_start, 32'd0);
        chk("rst_dvd", div_dividend, 32'd0);
        chk("rst_dvs", div_divisor, 32'd0);
        @(posedge clock); #1 reset = 1'b1;

        // DIV 100/7
        issue(1'b1, 32'd100, 32'd7, 1'b0, 32'd0, acc);
        chk("d100_acc_stall", acc, 32'd1);
        chk("d100_dvd", div_dividend, 32'd100);
        wait_idle(k, pulses);
        chk("d100_lat", k, 32'd34);
        chk("d100_pulses", pulses, 32'd1);
        chk("d100_lo", lo, 32'd14);
        chk("d100_hi", hi, 32'd2);

        // DIV -7/2
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, acc);
        wait_idle(k, pulses);
        chk("dm7_lo", lo, 32'hFFFF_FFFD);
        chk("dm7_hi", hi, 32'hFFFF_FFFF);

        // DIVU 0xFFFFFFFF/3, fix path
        issue(1'b0, 32'hFFFF_FFFF, 32'd3, 1'b0, 32'd0, acc);
        chk("fix_dvd", div_dividend, 32'h7FFF_FFFF);
        wait_idle(k, pulses);
        chk("fix_lat", k, 32'd35);
        chk("fix_lo", lo, 32'h5555_5555);
        chk("fix_hi", hi, 32'd0);

        // DIVU 0x80000001/0x80000000, fast
        issue(1'b0, 32'h8000_0001, 32'h8000_0000, 1'b0, 32'd0, acc);
        chk("big_acc_stall", acc, 32'd0);
        chk("big_stall", stall, 32'd0);
        chk("big_lo", lo, 32'd1);
        chk("big_hi", hi, 32'd1);

        // DIV 5/0 with a simultaneous mtlo that must lose
        issue(1'b1, 32'd5, 32'd0, 1'b1, 32'h0000_1234, acc);
        chk("z_acc_stall", acc, 32'd0);
        chk("z_lo", lo, 32'hFFFF_FFFF);
        chk("z_hi", hi, 32'd5);

        // Signed overflow
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, acc);
        wait_idle(k, pulses);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);

        // Random traffic, including ops and moves while busy
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock); #1;
            op_valid  = ($urandom_range(0, 3) == 0);
            op_signed = $urandom_range(0, 1) == 1;
            op_a      = rnd32();
            op_b      = rnd32();
            mthi      = ($urandom_range(0, 7) == 0);
            mtlo      = ($urandom_range(0, 7) == 0);
            wdata     = $urandom;
        end
        @(posedge clock); #1;
        op_valid = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        wait_idle(k, pulses);

        // Reset in the middle of RUN
        mt(32'h0000_AAAA, 32'h0000_5555);
        issue(1'b1, 32'h0000_1000, 32'd5, 1'b0, 32'd0, acc);
        repeat (10) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        chk("mr_hi", hi, 32'd0);
        chk("mr_lo", lo, 32'd0);
        chk("mr_stall", stall, 32'd0);
        @(posedge clock); #1 reset = 1'b1;
        issue(1'b1, 32'd9, 32'd3, 1'b0, 32'd0, acc);
        wait_idle(k, pulses);
        chk("r93_lo", lo, 32'd3);
        chk("r93_hi", hi, 32'd0);

        // Divider stuck busy: abort after 40 ACK/RUN cycles
        mt(32'h0000_DEAD, 32'h0000_BEEF);
        hang = 1'b1;
        issue(1'b1, 32'd50, 32'd5, 1'b0, 32'd0, acc);
        k = 0;
        while (!timeout_err && k < 100) begin
            @(posedge clock); #1;
            k++;
        end
        chk("to_edges", k, 32'd41);
        chk("to_terr", timeout_err, 32'd1);
        chk("to_stall", stall, 32'd0);
        chk("to_hi", hi, 32'h0000_DEAD);
        chk("to_lo", lo, 32'h0000_BEEF);
        hang = 1'b0;
        repeat (40) @(posedge clock);
        chk("to_sticky", timeout_err, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
